// File: rtl/ibp_pkg.sv
// Shared types for the indirect branch predictor update path.
// Table geometry, update payload and controller states.
package ibp_pkg;

  localparam int IBP_ENTRIES  = 512;
  localparam int IBP_IDX_BITS = 9;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target;
  } ibp_upd_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } ibp_ctrl_state_e;

endpackage

// File: rtl/ibp_upd_fifo.sv
// Two-write, one-read circular buffer of predictor updates.
// Port 0 always lands in the lower slot when both ports write.
module ibp_upd_fifo
  import ibp_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr0_en_i,
  input  ibp_upd_t         wr0_data_i,
  input  logic             wr1_en_i,
  input  ibp_upd_t         wr1_data_i,
  input  logic             rd_en_i,
  output ibp_upd_t         rd_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] slot1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ibp_upd_t         mem_q [DEPTH];

  always_comb begin
    slot1    = wr_ptr_q + PTR_W'(1);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en_i)
             + PTR_W'(wr1_en_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);
    cnt_d    = cnt_q + CNT_W'(wr0_en_i)
             + CNT_W'(wr1_en_i)
             - CNT_W'(rd_en_i);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!clr_i) begin
      if (wr0_en_i) begin
        mem_q[wr_ptr_q] <= wr0_data_i;
      end
      if (wr1_en_i) begin
        mem_q[wr0_en_i ? slot1 : wr_ptr_q] <= wr1_data_i;
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/ibp_update_ctrl.sv
// Update scheduler and flush sweeper in front of the IBP table.
// Two ports feed a small queue drained one entry per cycle.
module ibp_update_ctrl
  import ibp_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int ENTRIES  = IBP_ENTRIES,
  parameter  int IDX_BITS = IBP_IDX_BITS,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                upd0_valid_i,
  output logic                upd0_ready_o,
  input  logic [63:0]         upd0_pc_i,
  input  logic [63:0]         upd0_target_i,
  input  logic                upd1_valid_i,
  output logic                upd1_ready_o,
  input  logic [63:0]         upd1_pc_i,
  input  logic [63:0]         upd1_target_i,
  input  logic                flush_i,
  output logic                flush_busy_o,
  output logic                ibp_update_valid_o,
  output logic [63:0]         ibp_update_pc_o,
  output logic [63:0]         ibp_update_target_o,
  output logic                ibp_inval_valid_o,
  output logic [IDX_BITS-1:0] ibp_inval_idx_o,
  output logic [CNT_W-1:0]    occupancy_o
);

  ibp_ctrl_state_e     state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                rr_q, rr_d;
  logic [CNT_W-1:0]    occ, free;
  logic                two_free, one_free;
  logic                rdy0, rdy1;
  logic                enq0, enq1;
  logic                fav_en, oth_en;
  ibp_upd_t            p0, p1;
  ibp_upd_t            fav_d, oth_d;
  ibp_upd_t            head;
  logic                deq;
  logic                last;

  assign p0 = '{pc: upd0_pc_i, target: upd0_target_i};
  assign p1 = '{pc: upd1_pc_i, target: upd1_target_i};

  // Ready looks only at registered occupancy, never at valid.
  always_comb begin
    free     = CNT_W'(DEPTH) - occ;
    two_free = free >= CNT_W'(2);
    one_free = free == CNT_W'(1);
    rdy0     = two_free | (one_free & ~rr_q);
    rdy1     = two_free | (one_free & rr_q);
    enq0     = upd0_valid_i & rdy0;
    enq1     = upd1_valid_i & rdy1;
    fav_en   = rr_q ? enq1 : enq0;
    oth_en   = rr_q ? enq0 : enq1;
    fav_d    = rr_q ? p1 : p0;
    oth_d    = rr_q ? p0 : p1;
    rr_d     = fav_en ? ~rr_q : rr_q;
  end

  assign deq  = (state_q == IDLE) && (occ != '0);
  assign last = idx_q == IDX_BITS'(ENTRIES - 1);

  ibp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (flush_i),
    .wr0_en_i   (fav_en),
    .wr0_data_i (fav_d),
    .wr1_en_i   (oth_en),
    .wr1_data_i (oth_d),
    .rd_en_i    (deq),
    .rd_data_o  (head),
    .count_o    (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (flush_i) begin
          idx_d = '0;
        end else if (last) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_busy_o        = 1'b0;
    ibp_update_valid_o  = 1'b0;
    ibp_update_pc_o     = '0;
    ibp_update_target_o = '0;
    ibp_inval_valid_o   = 1'b0;
    ibp_inval_idx_o     = '0;
    unique case (state_q)
      IDLE: begin
        if (deq) begin
          ibp_update_valid_o  = 1'b1;
          ibp_update_pc_o     = head.pc;
          ibp_update_target_o = head.target;
        end
      end
      SWEEP: begin
        flush_busy_o      = 1'b1;
        ibp_inval_valid_o = 1'b1;
        ibp_inval_idx_o   = idx_q;
      end
      default: ;
    endcase
  end

  assign upd0_ready_o = rdy0;
  assign upd1_ready_o = rdy1;
  assign occupancy_o  = occ;

endmodule

// File: tb/tb_ibp_update_ctrl.sv
// Randomised bench for ibp_update_ctrl against a queue model.
// Model tracks queue contents, rr favour and sweep position.
module tb_ibp_update_ctrl;

  localparam int OW = 145;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, fl;
  logic [63:0] p0, t0, p1, t1;
  logic        r0, r1, busy, uv, iv;
  logic [63:0] upc, utg;
  logic [8:0]  iidx;
  logic [2:0]  occ;

  ibp_update_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .upd0_valid_i        (v0),
    .upd0_ready_o        (r0),
    .upd0_pc_i           (p0),
    .upd0_target_i       (t0),
    .upd1_valid_i        (v1),
    .upd1_ready_o        (r1),
    .upd1_pc_i           (p1),
    .upd1_target_i       (t1),
    .flush_i             (fl),
    .flush_busy_o        (busy),
    .ibp_update_valid_o  (uv),
    .ibp_update_pc_o     (upc),
    .ibp_update_target_o (utg),
    .ibp_inval_valid_o   (iv),
    .ibp_inval_idx_o     (iidx),
    .occupancy_o         (occ)
  );

  always #5 clk = ~clk;

  wire [OW-1:0] obs = {r0, r1, uv, upc, utg,
                       busy, iv, iidx, occ};

  int            vectors = 0;
  int            miscompares = 0;
  logic [127:0]  mq[$];
  bit            m_rr, m_sw;
  int            m_idx;
  bit            e_r0, e_r1, e_uv;
  logic [OW-1:0] expv;

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr  = 0;
    m_sw  = 0;
    m_idx = 0;
  endtask

  task automatic predict();
    int fr;
    logic [127:0] h;
    fr   = 4 - mq.size();
    e_r0 = fr >= 2 || (fr == 1 && !m_rr);
    e_r1 = fr >= 2 || (fr == 1 && m_rr);
    e_uv = !m_sw && mq.size() > 0;
    h    = e_uv ? mq[0] : 128'd0;
    expv = {e_r0, e_r1, e_uv, h, m_sw, m_sw,
            m_sw ? 9'(m_idx) : 9'd0, 3'(mq.size())};
  endtask

  task automatic advance();
    bit a0, a1;
    predict();
    a0 = v0 && e_r0;
    a1 = v1 && e_r1;
    if (e_uv) void'(mq.pop_front());
    if (!m_rr) begin
      if (a0) mq.push_back({p0, t0});
      if (a1) mq.push_back({p1, t1});
    end else begin
      if (a1) mq.push_back({p1, t1});
      if (a0) mq.push_back({p0, t0});
    end
    if (m_rr ? a1 : a0) m_rr = !m_rr;
    if (fl) begin
      mq.delete();
      m_sw  = 1;
      m_idx = 0;
    end else if (m_sw) begin
      if (m_idx == 511) m_sw = 0;
      else m_idx++;
    end
  endtask

  task automatic fin();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic zero_in();
    v0 = 0; v1 = 0; fl = 0;
    p0 = '0; t0 = '0; p1 = '0; t1 = '0;
  endtask

  task automatic rand_in();
    v0 = 1'($urandom()); p0 = r64(); t0 = r64();
    v1 = 1'($urandom()); p1 = r64(); t1 = r64();
    fl = 0;
  endtask

  task automatic test_reset();
    zero_in();
    rst_n = 0;
    model_reset();
    #2;
    predict();
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL reset obs=%h exp=%h", obs, expv);
    end
    vectors++;
    if ({uv, busy, iv, iidx, occ, upc} !== '0) begin
      miscompares++;
      $display("FAIL reset_zero uv=%b busy=%b occ=%0d exp 0",
               uv, busy, occ);
    end
    @(negedge clk);
    rst_n = 1;
    fin();
  endtask

  task automatic test_single();
    for (int c = 0; c < 4; c++) begin
      zero_in();
      if (c == 0) begin
        v0 = 1; p0 = 64'h1000; t0 = 64'h2000;
      end
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL single c=%0d obs=%h exp=%h", c, obs, expv);
      end
      if (c == 1) begin
        vectors++;
        if ({uv, upc, utg} !== {1'b1, 64'h1000, 64'h2000}) begin
          miscompares++;
          $display("FAIL single_write uv=%b pc=%h tg=%h exp 1/1000/2000",
                   uv, upc, utg);
        end
      end
      fin();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      zero_in();
      v0 = 1; p0 = 64'hA0 + 64'(c * 32); t0 = r64();
      v1 = 1; p1 = 64'hB0 + 64'(c * 32); t1 = r64();
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL b2b c=%0d obs=%h exp=%h", c, obs, expv);
      end
      fin();
    end
    for (int c = 0; c < 5; c++) begin
      zero_in();
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL b2b_drain c=%0d obs=%h exp=%h", c, obs, expv);
      end
      fin();
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      rand_in();
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL random c=%0d obs=%h exp=%h", c, obs, expv);
      end
      fin();
    end
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 5; c++) begin
      zero_in();
      if (c < 2) begin
        v0 = 1; p0 = r64(); t0 = r64();
        v1 = 1; p1 = r64(); t1 = r64();
      end
      if (c == 4) fl = 1;
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL sweep_pre c=%0d obs=%h exp=%h", c, obs, expv);
      end
      fin();
    end
    for (int k = 0; k < 512; k++) begin
      zero_in();
      if (k == 10) begin
        v1 = 1; p1 = 64'h5550; t1 = 64'h6660;
      end
      if (k >= 100 && k < 104) begin
        v0 = 1; p0 = r64(); t0 = r64();
        v1 = 1; p1 = r64(); t1 = r64();
      end
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL sweep k=%0d obs=%h exp=%h", k, obs, expv);
      end
      fin();
    end
    zero_in();
    predict();
    @(negedge clk);
    vectors++;
    if ({busy, uv, upc, utg} !== {1'b0, 1'b1, 64'h5550, 64'h6660}) begin
      miscompares++;
      $display("FAIL sweep_first_idle busy=%b uv=%b pc=%h exp 0/1/5550",
               busy, uv, upc);
    end
    fin();
    for (int c = 0; c < 6; c++) begin
      zero_in();
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL sweep_drain c=%0d obs=%h exp=%h", c, obs, expv);
      end
      fin();
    end
  endtask

  task automatic test_reflush();
    int n;
    zero_in();
    fl = 1;
    fin();
    for (int k = 0; k <= 300; k++) begin
      rand_in();
      if (k == 300) fl = 1;
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reflush k=%0d obs=%h exp=%h", k, obs, expv);
      end
      fin();
    end
    n = 0;
    for (int i = 0; i < 600; i++) begin
      rand_in();
      predict();
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reflush_run i=%0d obs=%h exp=%h", i, obs, expv);
      end
      if (!busy) break;
      n++;
      fin();
    end
    fin();
    vectors++;
    if (n !== 512) begin
      miscompares++;
      $display("FAIL reflush_len cycles=%0d exp 512", n);
    end
  endtask

  task automatic test_reset_mid();
    zero_in();
    fl = 1;
    fin();
    for (int k = 0; k < 100; k++) begin
      rand_in();
      fin();
    end
    zero_in();
    #3;
    rst_n = 0;
    #1;
    model_reset();
    predict();
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL reset_mid obs=%h exp=%h", obs, expv);
    end
    vectors++;
    if ({busy, iv, iidx, uv, occ} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_zero busy=%b iv=%b idx=%0d exp 0",
               busy, iv, iidx);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    fin();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random(300);
    test_sweep();
    test_reflush();
    test_reset_mid();
    test_random(80);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
